match_controller: RTL and testbench

- Top-level match sequencer for the pong game.
- Gates the paddle/ball datapath, times the serve countdown, clears the scoreboard at match start, handles pause, and declares the winner once a score reaches the target.
- Sits above the game core. Consumes the per-point pulses and the 4-bit left/right scores; drives the datapath enable, serve release and scoreboard clear.

---
 rtl/match_controller_if.sv | 22 ++
 rtl/match_controller.sv | 170 +++++++++++++++++
 tb/tb_match_controller.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/match_controller_if.sv
// Link between the match sequencer and the pong game core: point pulses and
// scores flow up, datapath enable, serve release and scoreboard clear flow down.
interface match_controller_if;
  logic       pointLeft;
  logic       pointRight;
  logic [3:0] leftScore;
  logic [3:0] rightScore;
  logic       gameEnable;
  logic       serveRelease;
  logic       serveSide;
  logic       scoreResetn;

  modport master (
    input  pointLeft, pointRight, leftScore, rightScore,
    output gameEnable, serveRelease, serveSide, scoreResetn
  );

  modport slave (
    output pointLeft, pointRight, leftScore, rightScore,
    input  gameEnable, serveRelease, serveSide, scoreResetn
  );
endinterface

// File: rtl/match_controller.sv
// Pong match sequencer: clear, serve countdown, play/pause, point handling, winner.
// Define WIN_BY_TWO_EN to require a two-point lead (with a cap at 15) to win.
module match_controller #(
  parameter int WIN_SCORE   = 7,
  parameter int TICK_DIV    = 1000,
  parameter int SERVE_TICKS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pause,
  match_controller_if.master    core,
  output logic [1:0]            winner,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SERVE  = 3'd2,
    PLAY   = 3'd3,
    PAUSED = 3'd4,
    POINT  = 3'd5,
    OVER   = 3'd6
  } stateT;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = $clog2(SERVE_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(SERVE_TICKS - 1);
  localparam logic [4:0]    WIN        = 5'(WIN_SCORE);

  stateT         stateReg, stateNext;
  logic [PW-1:0] presc, prescNext;
  logic [TW-1:0] tick, tickNext;
  logic          pointPhase, pointPhaseNext;
  logic          scorerRight, scorerRightNext;
  logic          gameEnableReg, gameEnableNext;
  logic          releaseReg, releaseNext;
  logic          serveSideReg, serveSideNext;
  logic          scoreResetnReg, scoreResetnNext;
  logic [1:0]    winnerReg, winnerNext;
  logic [4:0]    l5, r5;
  logic          leftWins, rightWins;

  assign l5 = {1'b0, core.leftScore};
  assign r5 = {1'b0, core.rightScore};

  always_comb begin
    leftWins  = 1'b0;
    rightWins = 1'b0;
`ifdef WIN_BY_TWO_EN
    if (l5 == 5'd15 || r5 == 5'd15) begin
      leftWins  = l5 > r5;
      rightWins = r5 > l5;
    end else begin
      leftWins  = (l5 >= WIN) && (l5 >= r5 + 5'd2);
      rightWins = (r5 >= WIN) && (r5 >= l5 + 5'd2);
    end
`else
    leftWins  = l5 >= WIN;
    rightWins = r5 >= WIN;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg       <= IDLE;
      presc          <= '0;
      tick           <= '0;
      pointPhase     <= 1'b0;
      scorerRight    <= 1'b0;
      gameEnableReg  <= 1'b0;
      releaseReg     <= 1'b0;
      serveSideReg   <= 1'b0;
      scoreResetnReg <= 1'b1;
      winnerReg      <= 2'b00;
    end else begin
      stateReg       <= stateNext;
      presc          <= prescNext;
      tick           <= tickNext;
      pointPhase     <= pointPhaseNext;
      scorerRight    <= scorerRightNext;
      gameEnableReg  <= gameEnableNext;
      releaseReg     <= releaseNext;
      serveSideReg   <= serveSideNext;
      scoreResetnReg <= scoreResetnNext;
      winnerReg      <= winnerNext;
    end
  end

  // Outputs are computed from the state being entered so they line up with it.
  always_comb begin
    stateNext       = stateReg;
    prescNext       = presc;
    tickNext        = tick;
    pointPhaseNext  = 1'b0;
    scorerRightNext = scorerRight;
    releaseNext     = 1'b0;
    serveSideNext   = serveSideReg;
    winnerNext      = winnerReg;

    case (stateReg)
      IDLE: if (start) stateNext = CLEAR;
      CLEAR: stateNext = SERVE;
      SERVE: begin
        if (presc == PRESC_LAST) begin
          prescNext = '0;
          if (tick == TICK_LAST) begin
            tickNext    = '0;
            releaseNext = 1'b1;
            stateNext   = PLAY;
          end else begin
            tickNext = tick + TW'(1);
          end
        end else begin
          prescNext = presc + PW'(1);
        end
      end
      PLAY: begin
        if (core.pointLeft) begin
          scorerRightNext = 1'b0;
          stateNext       = POINT;
        end else if (core.pointRight) begin
          scorerRightNext = 1'b1;
          stateNext       = POINT;
        end else if (pause) begin
          stateNext = PAUSED;
        end
      end
      PAUSED: if (pause) stateNext = PLAY;
      // First POINT cycle waits for the scoreboard to register the new score.
      POINT: begin
        if (!pointPhase) begin
          pointPhaseNext = 1'b1;
        end else if (leftWins) begin
          winnerNext = 2'b01;
          stateNext  = OVER;
        end else if (rightWins) begin
          winnerNext = 2'b10;
          stateNext  = OVER;
        end else begin
          serveSideNext = scorerRight;
          prescNext     = '0;
          tickNext      = '0;
          stateNext     = SERVE;
        end
      end
      OVER: if (start) stateNext = CLEAR;
      default: stateNext = IDLE;
    endcase

    if (stateNext == CLEAR) begin
      winnerNext    = 2'b00;
      serveSideNext = 1'b0;
      prescNext     = '0;
      tickNext      = '0;
    end
    gameEnableNext  = (stateNext == PLAY);
    scoreResetnNext = (stateNext != CLEAR);
  end

  assign core.gameEnable   = gameEnableReg;
  assign core.serveRelease = releaseReg;
  assign core.serveSide    = serveSideReg;
  assign core.scoreResetn  = scoreResetnReg;
  assign winner            = winnerReg;
  assign state             = stateReg;

endmodule

// File: tb/tb_match_controller.sv
// Directed-vector bench for match_controller with TICK_DIV=4, SERVE_TICKS=3, WIN_SCORE=7.
module tb_match_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] winner;
  logic [2:0] state;
  int         vectorCount = 0;
  int         missCount = 0;
  int         cnt;

  match_controller_if core();

  match_controller #(.WIN_SCORE(7), .TICK_DIV(4), .SERVE_TICKS(3)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .pause(pause),
    .core(core.master),
    .winner(winner),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Inputs are held for exactly one active edge, then dropped.
  task automatic applyStimulus(input logic s, input logic p, input logic pl, input logic pr);
    start = s;
    pause = p;
    core.pointLeft = pl;
    core.pointRight = pr;
    step(1);
    start = 1'b0;
    pause = 1'b0;
    core.pointLeft = 1'b0;
    core.pointRight = 1'b0;
  endtask

  task automatic waitRelease(output int n);
    n = 0;
    while (core.serveRelease !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    if (n >= 40) $display("[TB] FAIL serveTimeout: got %0d cycles, expected a release", n);
  endtask

  // Score a point, then update the scoreboard as the game core would.
  task automatic scorePoint(input logic pl, input logic pr, input logic [3:0] l, input logic [3:0] r);
    applyStimulus(1'b0, 1'b0, pl, pr);
    core.leftScore = l;
    core.rightScore = r;
    step(2);
  endtask

  initial begin
    core.pointLeft = 1'b0;
    core.pointRight = 1'b0;
    core.leftScore = 4'd0;
    core.rightScore = 4'd0;
    step(3);
    checkOutput("rstState", state, 0);
    checkOutput("rstGameEnable", core.gameEnable, 0);
    checkOutput("rstRelease", core.serveRelease, 0);
    checkOutput("rstServeSide", core.serveSide, 0);
    checkOutput("rstScoreResetn", core.scoreResetn, 1);
    checkOutput("rstWinner", winner, 0);
    reset = 1'b1;
    step(1);

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("idleIgnores", state, 0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("clearState", state, 1);
    checkOutput("clearScoreResetn", core.scoreResetn, 0);
    step(1);
    checkOutput("serveState", state, 2);
    checkOutput("serveScoreResetn", core.scoreResetn, 1);
    waitRelease(cnt);
    checkOutput("serveLatency", cnt, 12);
    checkOutput("releaseState", state, 3);
    step(1);
    checkOutput("releasePulse", core.serveRelease, 0);
    checkOutput("playEnable", core.gameEnable, 1);

    core.rightScore = 4'd2;
    step(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("point1State", state, 5);
    checkOutput("point1Enable", core.gameEnable, 0);
    core.rightScore = 4'd3;
    step(1);
    checkOutput("point2State", state, 5);
    checkOutput("point2Enable", core.gameEnable, 0);
    step(1);
    checkOutput("reserveState", state, 2);
    checkOutput("reserveSide", core.serveSide, 1);
    checkOutput("reserveWinner", winner, 0);
    waitRelease(cnt);
    checkOutput("reserveLatency", cnt, 12);
    step(1);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("pausedState", state, 4);
    checkOutput("pausedEnable", core.gameEnable, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("pausedIgnoresPoint", state, 4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("resumeState", state, 3);
    checkOutput("resumeEnable", core.gameEnable, 1);

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("triState", state, 5);
    core.leftScore = 4'd1;
    step(2);
    checkOutput("triServe", state, 2);
    checkOutput("triSideLeft", core.serveSide, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("serveIgnoresStart", state, 2);
    checkOutput("serveNoClear", core.scoreResetn, 1);
    waitRelease(cnt);
    checkOutput("startSkipLatency", cnt, 11);
    step(1);

    core.leftScore = 4'd6;
    scorePoint(1'b1, 1'b0, 4'd7, 4'd3);
    checkOutput("leftWinState", state, 6);
    checkOutput("leftWinner", winner, 1);
    checkOutput("overEnable", core.gameEnable, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("overHold", winner, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("restartState", state, 1);
    checkOutput("restartClear", core.scoreResetn, 0);
    checkOutput("restartWinner", winner, 0);
    core.leftScore = 4'd0;
    core.rightScore = 4'd0;
    step(1);
    checkOutput("restartServe", state, 2);

    waitRelease(cnt);
    step(1);
    scorePoint(1'b0, 1'b1, 4'd6, 4'd6);
    checkOutput("belowWinState", state, 2);
    checkOutput("belowWinSide", core.serveSide, 1);
    waitRelease(cnt);
    step(1);
    scorePoint(1'b0, 1'b1, 4'd4, 4'd7);
    checkOutput("rightWinState", state, 6);
    checkOutput("rightWinner", winner, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    core.leftScore = 4'd0;
    core.rightScore = 4'd0;
    step(1);

`ifdef WIN_BY_TWO_EN
    waitRelease(cnt);
    step(1);
    scorePoint(1'b1, 1'b0, 4'd7, 4'd6);
    checkOutput("byTwo76State", state, 2);
    checkOutput("byTwo76Winner", winner, 0);
    waitRelease(cnt);
    step(1);
    scorePoint(1'b1, 1'b0, 4'd8, 4'd6);
    checkOutput("byTwo86Winner", winner, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    waitRelease(cnt);
    step(1);
    scorePoint(1'b1, 1'b0, 4'd15, 4'd14);
    checkOutput("capState", state, 6);
    checkOutput("capWinner", winner, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
`endif

    waitRelease(cnt);
    step(2);
    checkOutput("midPlay", state, 3);
    reset = 1'b0;
    #1;
    checkOutput("asyncRstState", state, 0);
    checkOutput("asyncRstEnable", core.gameEnable, 0);
    checkOutput("asyncRstWinner", winner, 0);
    step(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end
endmodule
